// File: rtl/bip_control.sv
// bip_control: single-cycle controller for a small accumulator CPU.
// Sequences IDLE -> RUN -> HALT, decodes the opcode into datapath
// controls, steps the program counter, counts RUN cycles and flags
// undefined opcodes.
// Optional build macro: BIP_BRANCH_EN adds BEQ (8), BNE (9) and JMP (10).
module bip_control #(
  parameter int PC_WIDTH      = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int OPERAND_WIDTH = 11,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  Start,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] Instruction,
  input  logic                                  AccZero,
  output logic [PC_WIDTH-1:0]                   PC,
  output logic [OPERAND_WIDTH-1:0]              Operand,
  output logic                                  WrPC,
  output logic [1:0]                            SelA,
  output logic                                  SelB,
  output logic                                  WrAcc,
  output logic                                  Op,
  output logic                                  WrRam,
  output logic                                  RdRam,
  output logic                                  Running,
  output logic                                  Halted,
  output logic                                  Illegal,
  output logic [CNT_WIDTH-1:0]                  CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOADI = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI  = OPCODE_WIDTH'(7);
`ifdef BIP_BRANCH_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(10);
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                   r_state;
  state_t                   w_next_state;
  logic [PC_WIDTH-1:0]      r_pc;
  logic [PC_WIDTH-1:0]      w_next_pc;
  logic [PC_WIDTH-1:0]      w_pc_inc;
  logic [PC_WIDTH-1:0]      w_pc_target;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic [CNT_WIDTH-1:0]     w_next_cnt;
  logic                     r_illegal;
  logic                     w_next_illegal;
  logic                     r_running;
  logic                     r_halted;
  logic [OPCODE_WIDTH-1:0]  w_opcode;
  logic [OPERAND_WIDTH-1:0] w_operand;

  logic       w_wrpc;
  logic [1:0] w_sela;
  logic       w_selb;
  logic       w_wracc;
  logic       w_op;
  logic       w_wrram;
  logic       w_rdram;
  logic       w_undef;
  logic       w_take;

  assign w_opcode    = Instruction[OPCODE_WIDTH+OPERAND_WIDTH-1:OPERAND_WIDTH];
  assign w_operand   = Instruction[OPERAND_WIDTH-1:0];
  assign w_pc_inc    = r_pc + PC_WIDTH'(1);
  assign w_pc_target = w_operand[PC_WIDTH-1:0];

`ifndef BIP_BRANCH_EN
  // AccZero only steers branches, so it has no consumer in this build.
  logic w_unused_acczero;
  assign w_unused_acczero = AccZero;
`endif

  // Opcode decode: controls are live only in RUN, all zero otherwise.
  always_comb begin
    w_wrpc  = 1'b0;
    w_sela  = 2'b00;
    w_selb  = 1'b0;
    w_wracc = 1'b0;
    w_op    = 1'b0;
    w_wrram = 1'b0;
    w_rdram = 1'b0;
    w_undef = 1'b0;
    w_take  = 1'b0;
    if (r_state == S_RUN) begin
      case (w_opcode)
        OP_HALT: begin
          w_wrpc = 1'b0;
        end
        OP_STORE: begin
          w_wrpc = 1'b1; w_wrram = 1'b1;
        end
        OP_LOAD: begin
          w_wrpc = 1'b1; w_wracc = 1'b1; w_rdram = 1'b1;
        end
        OP_LOADI: begin
          w_wrpc = 1'b1; w_sela = 2'd1; w_wracc = 1'b1;
        end
        OP_ADD: begin
          w_wrpc = 1'b1; w_sela = 2'd2; w_wracc = 1'b1; w_rdram = 1'b1;
        end
        OP_ADDI: begin
          w_wrpc = 1'b1; w_sela = 2'd2; w_selb = 1'b1; w_wracc = 1'b1;
        end
        OP_SUB: begin
          w_wrpc = 1'b1; w_sela = 2'd2; w_wracc = 1'b1; w_op = 1'b1;
          w_rdram = 1'b1;
        end
        OP_SUBI: begin
          w_wrpc = 1'b1; w_sela = 2'd2; w_selb = 1'b1; w_wracc = 1'b1;
          w_op = 1'b1;
        end
`ifdef BIP_BRANCH_EN
        OP_BEQ: begin
          w_wrpc = 1'b1; w_take = AccZero;
        end
        OP_BNE: begin
          w_wrpc = 1'b1; w_take = ~AccZero;
        end
        OP_JMP: begin
          w_wrpc = 1'b1; w_take = 1'b1;
        end
`endif
        default: begin
          // Undefined opcode behaves as a NOP and is flagged.
          w_wrpc  = 1'b1;
          w_undef = 1'b1;
        end
      endcase
    end else begin
      w_wrpc = 1'b0;
    end
  end

  // Next-state, next-PC, cycle counter and sticky illegal flag.
  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_pc;
    w_next_cnt     = r_cnt;
    w_next_illegal = r_illegal;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (Start) begin
          w_next_state   = S_RUN;
          w_next_pc      = {PC_WIDTH{1'b0}};
          w_next_cnt     = {CNT_WIDTH{1'b0}};
          w_next_illegal = 1'b0;
        end else begin
          w_next_state = r_state;
        end
      end
      S_RUN: begin
        if (r_cnt != CNT_MAX) begin
          w_next_cnt = r_cnt + CNT_WIDTH'(1);
        end else begin
          w_next_cnt = r_cnt;
        end
        if (w_undef) begin
          w_next_illegal = 1'b1;
        end else begin
          w_next_illegal = r_illegal;
        end
        if (w_opcode == OP_HALT) begin
          w_next_state = S_HALT;
        end else if (w_take) begin
          w_next_pc = w_pc_target;
        end else begin
          w_next_pc = w_pc_inc;
        end
      end
      default: begin
        w_next_state   = S_IDLE;
        w_next_pc      = {PC_WIDTH{1'b0}};
        w_next_cnt     = {CNT_WIDTH{1'b0}};
        w_next_illegal = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; status flags registered too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= {PC_WIDTH{1'b0}};
      r_cnt     <= {CNT_WIDTH{1'b0}};
      r_illegal <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_cnt     <= w_next_cnt;
      r_illegal <= w_next_illegal;
      r_running <= (w_next_state == S_RUN);
      r_halted  <= (w_next_state == S_HALT);
    end
  end

  assign PC         = r_pc;
  assign Operand    = w_operand;
  assign WrPC       = w_wrpc;
  assign SelA       = w_sela;
  assign SelB       = w_selb;
  assign WrAcc      = w_wracc;
  assign Op         = w_op;
  assign WrRam      = w_wrram;
  assign RdRam      = w_rdram;
  assign Running    = r_running;
  assign Halted     = r_halted;
  assign Illegal    = r_illegal;
  assign CycleCount = r_cnt;

endmodule

// File: tb/tb_bip_control.sv
// Directed testbench for bip_control: default-size instance for decode,
// sequencing and reset; a PC_WIDTH=3 / CNT_WIDTH=2 instance for wrap and
// counter saturation.
module tb_bip_control;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [15:0] Instruction;
  logic        AccZero;
  logic [10:0] PC;
  logic [10:0] Operand;
  logic        WrPC, SelB, WrAcc, Op, WrRam, RdRam;
  logic [1:0]  SelA;
  logic        Running, Halted, Illegal;
  logic [15:0] CycleCount;
  logic [7:0]  ctrl;

  logic        s_start;
  logic [15:0] s_instr;
  logic [2:0]  s_pc;
  logic [10:0] s_operand;
  logic        s_wrpc, s_selb, s_wracc, s_op, s_wrram, s_rdram;
  logic [1:0]  s_sela;
  logic        s_running, s_halted, s_illegal;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  assign ctrl = {WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam};

  bip_control u_dut (
    .clk(clk), .rst(rst), .Start(Start), .Instruction(Instruction),
    .AccZero(AccZero), .PC(PC), .Operand(Operand), .WrPC(WrPC),
    .SelB(SelB), .WrAcc(WrAcc), .Op(Op), .WrRam(WrRam), .RdRam(RdRam),
    .SelA(SelA), .Running(Running), .Halted(Halted), .Illegal(Illegal),
    .CycleCount(CycleCount)
  );

  bip_control #(.PC_WIDTH(3), .CNT_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .Start(s_start), .Instruction(s_instr),
    .AccZero(1'b0), .PC(s_pc), .Operand(s_operand), .WrPC(s_wrpc),
    .SelB(s_selb), .WrAcc(s_wracc), .Op(s_op), .WrRam(s_wrram),
    .RdRam(s_rdram), .SelA(s_sela), .Running(s_running),
    .Halted(s_halted), .Illegal(s_illegal), .CycleCount(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [10:0] opd);
    return {op, opd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b1; Instruction = mk(5'd3, 11'd5); AccZero = 1'b0;
    s_start = 1'b1; s_instr = mk(5'd31, 11'd0);
    tick(); tick();
    n_cmp++; if (PC !== 11'd0) begin n_err++; $display("FAIL reset_pc: got %0h want 0", PC); end
    n_cmp++; if (ctrl !== 8'h00) begin n_err++; $display("FAIL reset_ctrl: got %0h want 0", ctrl); end
    n_cmp++; if ({Running, Halted, Illegal} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {Running, Halted, Illegal}); end
    n_cmp++; if (CycleCount !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", CycleCount); end
    rst = 1'b0; Start = 1'b0; s_start = 1'b0;
    tick();
    n_cmp++; if ({Running, Halted, ctrl} !== 10'd0) begin n_err++; $display("FAIL idle_after_reset: got %0h want 0", {Running, Halted, ctrl}); end
  endtask

  task automatic test_program();
    logic [15:0] prog [4];
    logic [7:0]  exp  [4];
    prog[0] = mk(5'd3, 11'd5); exp[0] = 8'b1_01_0_1_0_0_0;
    prog[1] = mk(5'd5, 11'd3); exp[1] = 8'b1_10_1_1_0_0_0;
    prog[2] = mk(5'd1, 11'd1); exp[2] = 8'b1_00_0_0_0_1_0;
    prog[3] = mk(5'd0, 11'd0); exp[3] = 8'b0_00_0_0_0_0_0;
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Instruction = prog[i];
      #1;
      n_cmp++; if (PC !== 11'(i)) begin n_err++; $display("FAIL prog_pc[%0d]: got %0d want %0d", i, PC, i); end
      n_cmp++; if (ctrl !== exp[i]) begin n_err++; $display("FAIL prog_ctrl[%0d]: got %b want %b", i, ctrl, exp[i]); end
      n_cmp++; if (Running !== 1'b1) begin n_err++; $display("FAIL prog_running[%0d]: got %b want 1", i, Running); end
      n_cmp++; if (Operand !== prog[i][10:0]) begin n_err++; $display("FAIL prog_operand[%0d]: got %0h want %0h", i, Operand, prog[i][10:0]); end
      tick();
    end
    n_cmp++; if ({Running, Halted} !== 2'b01) begin n_err++; $display("FAIL prog_halted: got %b want 01", {Running, Halted}); end
    n_cmp++; if (PC !== 11'd3) begin n_err++; $display("FAIL prog_pc_hold: got %0d want 3", PC); end
    n_cmp++; if (CycleCount !== 16'd4) begin n_err++; $display("FAIL prog_cnt: got %0d want 4", CycleCount); end
    n_cmp++; if (ctrl !== 8'h00) begin n_err++; $display("FAIL halt_ctrl: got %b want 0", ctrl); end
  endtask

  task automatic test_decode();
    logic [15:0] prog [5];
    logic [7:0]  exp  [5];
    prog[0] = mk(5'd2, 11'd9);  exp[0] = 8'b1_00_0_1_0_0_1;
    prog[1] = mk(5'd4, 11'd9);  exp[1] = 8'b1_10_0_1_0_0_1;
    prog[2] = mk(5'd6, 11'd9);  exp[2] = 8'b1_10_0_1_1_0_1;
    prog[3] = mk(5'd7, 11'd9);  exp[3] = 8'b1_10_1_1_1_0_0;
    prog[4] = mk(5'd0, 11'd0);  exp[4] = 8'b0_00_0_0_0_0_0;
    Start = 1'b1; tick();
    n_cmp++; if (CycleCount !== 16'd0) begin n_err++; $display("FAIL restart_cnt: got %0d want 0", CycleCount); end
    n_cmp++; if ({Running, Halted} !== 2'b10) begin n_err++; $display("FAIL restart_state: got %b want 10", {Running, Halted}); end
    for (int i = 0; i < 5; i++) begin
      Start = (i < 3) ? 1'b1 : 1'b0;
      Instruction = prog[i];
      #1;
      n_cmp++; if (PC !== 11'(i)) begin n_err++; $display("FAIL dec_pc[%0d]: got %0d want %0d", i, PC, i); end
      n_cmp++; if (ctrl !== exp[i]) begin n_err++; $display("FAIL dec_ctrl[%0d]: got %b want %b", i, ctrl, exp[i]); end
      tick();
    end
    n_cmp++; if (CycleCount !== 16'd5) begin n_err++; $display("FAIL dec_cnt: got %0d want 5", CycleCount); end
  endtask

  task automatic test_illegal();
    Start = 1'b1; tick(); Start = 1'b0;
    Instruction = mk(5'd3, 11'd1); tick(); tick();
    Instruction = mk(5'd31, 11'd0);
    #1;
    n_cmp++; if (ctrl !== 8'b1000_0000) begin n_err++; $display("FAIL ill_ctrl: got %b want 10000000", ctrl); end
    n_cmp++; if (Illegal !== 1'b0) begin n_err++; $display("FAIL ill_before: got %b want 0", Illegal); end
    tick();
    n_cmp++; if (PC !== 11'd3) begin n_err++; $display("FAIL ill_pc: got %0d want 3", PC); end
    n_cmp++; if (Illegal !== 1'b1) begin n_err++; $display("FAIL ill_set: got %b want 1", Illegal); end
    Instruction = mk(5'd3, 11'd1); tick();
    Instruction = mk(5'd0, 11'd0); tick(); tick();
    n_cmp++; if ({Halted, Illegal} !== 2'b11) begin n_err++; $display("FAIL ill_sticky: got %b want 11", {Halted, Illegal}); end
    Start = 1'b1; tick(); Start = 1'b0;
    n_cmp++; if (Illegal !== 1'b0) begin n_err++; $display("FAIL ill_clear: got %b want 0", Illegal); end
    Instruction = mk(5'd0, 11'd0); tick();
  endtask

  task automatic test_branch();
    Start = 1'b1; tick(); Start = 1'b0;
`ifdef BIP_BRANCH_EN
    Instruction = mk(5'd8, 11'h007); AccZero = 1'b1;
    #1;
    n_cmp++; if (ctrl !== 8'b1000_0000) begin n_err++; $display("FAIL beq_ctrl: got %b want 10000000", ctrl); end
    tick();
    n_cmp++; if (PC !== 11'd7) begin n_err++; $display("FAIL beq_taken: got %0d want 7", PC); end
    AccZero = 1'b0; tick();
    n_cmp++; if (PC !== 11'd8) begin n_err++; $display("FAIL beq_not: got %0d want 8", PC); end
    Instruction = mk(5'd9, 11'h003); tick();
    n_cmp++; if (PC !== 11'd3) begin n_err++; $display("FAIL bne_taken: got %0d want 3", PC); end
    Instruction = mk(5'd10, 11'h7FF); tick();
    n_cmp++; if (PC !== 11'd2047) begin n_err++; $display("FAIL jmp: got %0d want 2047", PC); end
    n_cmp++; if (Illegal !== 1'b0) begin n_err++; $display("FAIL br_illegal: got %b want 0", Illegal); end
`else
    Instruction = mk(5'd8, 11'h007); AccZero = 1'b1;
    #1;
    n_cmp++; if (ctrl !== 8'b1000_0000) begin n_err++; $display("FAIL beq_nop_ctrl: got %b want 10000000", ctrl); end
    tick();
    n_cmp++; if (PC !== 11'd1) begin n_err++; $display("FAIL beq_nop_pc: got %0d want 1", PC); end
    n_cmp++; if (Illegal !== 1'b1) begin n_err++; $display("FAIL beq_nop_illegal: got %b want 1", Illegal); end
`endif
    AccZero = 1'b0;
    Instruction = mk(5'd0, 11'd0); tick();
  endtask

  task automatic test_reset_midrun();
    Start = 1'b1; tick(); Start = 1'b0;
    Instruction = mk(5'd3, 11'd1);
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (PC !== 11'd5) begin n_err++; $display("FAIL mid_pc5: got %0d want 5", PC); end
    rst = 1'b1; Start = 1'b1; tick();
    n_cmp++; if ({Running, Halted} !== 2'b00) begin n_err++; $display("FAIL mid_state: got %b want 00", {Running, Halted}); end
    n_cmp++; if (PC !== 11'd0) begin n_err++; $display("FAIL mid_pc: got %0d want 0", PC); end
    n_cmp++; if (CycleCount !== 16'd0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", CycleCount); end
    n_cmp++; if (ctrl !== 8'h00) begin n_err++; $display("FAIL mid_ctrl: got %b want 0", ctrl); end
    rst = 1'b0; Start = 1'b0; tick();
  endtask

  task automatic test_wrap();
    logic [2:0] ep;
    logic [1:0] ec;
    s_instr = mk(5'd31, 11'd0);
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ep = 3'(i);
      ec = (i > 3) ? 2'd3 : 2'(i);
      n_cmp++; if (s_pc !== ep) begin n_err++; $display("FAIL wrap_pc[%0d]: got %0d want %0d", i, s_pc, ep); end
      n_cmp++; if (s_cnt !== ec) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, s_cnt, ec); end
      tick();
    end
    n_cmp++; if (s_running !== 1'b1) begin n_err++; $display("FAIL wrap_running: got %b want 1", s_running); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_decode();
    test_illegal();
    test_branch();
    test_reset_midrun();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
